// File: rtl/tagger_engine.sv
// Time tagger: detects per-channel rising edges on synchronous detector
// levels while running and buffers {wrap, mask, timestamp} records in a
// first-word-fall-through buffer. A record is also emitted whenever the
// timestamp sits at all-ones, so software can extend the count.
//
// Ports:
//   clk, reset      - sole clock; asynchronous active-high reset
//   detectors       - NCHAN detector levels, synchronous to clk
//   start_det       - strobe: IDLE -> RUN
//   stop_det        - strobe: RUN -> IDLE (wins over start_det)
//   reset_counter   - strobe: clear timestamp and lost_count
//   sample          - head record {wrap, mask, ts}, zero when empty
//   sample_rdy      - head record valid
//   sample_ack      - consumer pops the head record
//   running         - high while in RUN
//   lost_count      - records dropped on a full buffer (saturating)
//   fifo_level      - records currently buffered
module tagger_engine #(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned TS_WIDTH   = 36,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOST_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCHAN-1:0]            detectors,
    input  logic                        start_det,
    input  logic                        stop_det,
    input  logic                        reset_counter,
    output logic [NCHAN+TS_WIDTH:0]     sample,
    output logic                        sample_rdy,
    input  logic                        sample_ack,
    output logic                        running,
    output logic [LOST_WIDTH-1:0]       lost_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned REC_W = 1 + NCHAN + TS_WIDTH;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [TS_WIDTH-1:0]   ts_q;
    logic [NCHAN-1:0]      det_q;
    logic [NCHAN-1:0]      det_qq;
    logic [NCHAN-1:0]      rise;
    logic                  ts_max;
    logic                  gen;
    logic [REC_W-1:0]      gen_rec;

    logic                  stage_valid;
    logic [REC_W-1:0]      stage_rec;

    logic [REC_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  xfer;
    logic                  wr_en;
    logic                  drop;
    logic [LOST_WIDTH-1:0] lost_q;

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state; stop_det has priority over start_det
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_det && !stop_det) state_d = RUN;
            RUN:  if (stop_det)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timestamp counter; reset_counter overrides the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else if (reset_counter) begin
            ts_q <= '0;
        end else if (state_q == RUN) begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    // Detector history runs in both states so entering RUN sees no stale edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_q  <= '0;
            det_qq <= '0;
        end else begin
            det_q  <= detectors;
            det_qq <= det_q;
        end
    end

    assign rise    = det_q & ~det_qq;
    assign ts_max  = &ts_q;
    assign gen     = (state_q == RUN) && ((|rise) || ts_max);
    assign gen_rec = {ts_max, rise, ts_q};

    // Record stage: gives the two-edge latency from sampled edge to buffer write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_rec   <= '0;
        end else begin
            stage_valid <= gen;
            stage_rec   <= gen_rec;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == LVL_W'(FIFO_DEPTH));
    assign xfer  = !empty && sample_ack;
    // A full buffer still accepts a write when the head leaves on the same edge
    assign wr_en = stage_valid && (!full || xfer);
    assign drop  = stage_valid && full && !xfer;

    // Buffer storage (no reset; the read side is gated by the level)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= stage_rec;
        end
    end

    // Buffer pointers and level; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (xfer)  rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, xfer})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Dropped-record counter, saturating; reset_counter overrides
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_q <= '0;
        end else if (reset_counter) begin
            lost_q <= '0;
        end else if (drop && !(&lost_q)) begin
            lost_q <= lost_q + LOST_WIDTH'(1);
        end
    end

    assign sample     = empty ? '0 : mem[rd_ptr];
    assign sample_rdy = !empty;
    assign running    = (state_q == RUN);
    assign lost_count = lost_q;
    assign fifo_level = count;

endmodule

// File: doc/tagger_engine.md
TAGGER_ENGINE -- requirements
Module: tagger_engine

Interface
REQ-001 The block SHALL have the following parameters:
- NCHAN, default 4, number of detector channels.
- TS_WIDTH, default 36, timestamp counter width.
- FIFO_DEPTH, default 16, record buffer depth, power of 2, >= 2.
- LOST_WIDTH, default 16, dropped-record counter width.

REQ-002 The block SHALL have the following ports; W = 1+NCHAN+TS_WIDTH and L = log2(FIFO_DEPTH)+1:

| Port | Direction | Width | Meaning |
|---|---|---|---|
| clk | input | 1 | sole clock, all logic on its rising edge |
| reset | input | 1 | asynchronous, active-high |
| detectors | input | NCHAN | detector levels, already synchronous to clk |
| start_det | input | 1 | one-cycle strobe: begin tagging |
| stop_det | input | 1 | one-cycle strobe: stop tagging |
| reset_counter | input | 1 | one-cycle strobe: clear timestamp and lost counter |
| sample | output | W | head record {wrap, mask[NCHAN-1:0], ts[TS_WIDTH-1:0]} |
| sample_rdy | output | 1 | sample is valid |
| sample_ack | input | 1 | consumer takes sample |
| running | output | 1 | high while in RUN |
| lost_count | output | LOST_WIDTH | records dropped on full buffer |
| fifo_level | output | L | records currently buffered |

Function
REQ-003 The controller SHALL have two states, IDLE and RUN; running SHALL be high exactly in RUN.
REQ-004 start_det in IDLE SHALL enter RUN at the next edge; stop_det in RUN SHALL enter IDLE at the next edge; stop_det SHALL win when both strobes are high together.
REQ-005 The timestamp counter SHALL increment by 1 each cycle in RUN, hold in IDLE, and wrap from all-ones to 0.
REQ-006 reset_counter SHALL clear the timestamp and lost_count at the next edge, in either state, overriding increment and saturation.
REQ-007 detectors SHALL be registered into det_q and det_qq every cycle in both states, so no spurious edge occurs on entry to RUN.
REQ-008 rise = det_q & ~det_qq SHALL be the per-channel rising-edge mask.
REQ-009 In RUN, a record SHALL be generated in any cycle where rise != 0 or the timestamp equals all-ones; at most one record SHALL be generated per cycle.
REQ-010 The record SHALL carry wrap=1 iff the timestamp is all-ones, mask = rise, and ts = the current timestamp value.
REQ-011 A wrap-only record SHALL have mask = 0.
REQ-012 Latency: a detectors rising transition sampled at edge k SHALL be written at edge k+2, with sample_rdy visible after edge k+2 if the buffer was empty.
REQ-013 The buffer SHALL be first-word-fall-through: sample shows the head record whenever sample_rdy=1.
REQ-014 A transfer SHALL occur at an edge with sample_rdy=1 and sample_ack=1; sample SHALL be held stable while sample_rdy=1 and sample_ack=0.
REQ-015 sample_ack while empty SHALL be ignored.
REQ-016 When fifo_level=FIFO_DEPTH and no transfer occurs in the same cycle, a generated record SHALL be dropped and lost_count incremented, saturating at all-ones.
REQ-017 A write when full with a simultaneous transfer SHALL be accepted, and the level SHALL stay FIFO_DEPTH.
REQ-018 A simultaneous write and transfer at any level SHALL leave fifo_level unchanged.
REQ-019 After stop_det, already-buffered records SHALL still drain normally, and no record SHALL be generated after the edge that enters IDLE.
REQ-020 Records SHALL leave the buffer in generation order; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 While reset=1, the block SHALL be in IDLE with running=0, timestamp=0, det_q=det_qq=0, buffer empty (fifo_level=0, sample_rdy=0), sample=0 and lost_count=0.
REQ-022 Reset asserted mid-operation SHALL discard buffered records and recover fully after reset=0, with no record generated until start_det.

Verification
REQ-023 Basic tagging: NCHAN=4; start_det; detectors 0000->0101 while timestamp=T -> one record {0,0101,T} with sample_rdy two edges after the sample edge.
REQ-024 Wrap record: TS_WIDTH=4, run 15 cycles with no edges -> record {1,0000,4'hF}; the next timestamp is 0.
REQ-025 Overflow: FIFO_DEPTH=4, sample_ack=0, 6 distinct edge events -> fifo_level=4, lost_count=2, and the first 4 records drain in order.
REQ-026 Strobe precedence: start_det and stop_det together in IDLE -> remain IDLE; reset_counter during RUN at timestamp 100 -> timestamp 0 on the next cycle and lost_count=0.
REQ-027 Backpressure: sample_rdy held with sample_ack=0 for 10 cycles while new records arrive -> sample stable, and a later ack pops exactly one record per acked edge.
REQ-028 Reset mid-run: reset pulse with 3 records buffered -> sample_rdy=0, running=0, and after start_det timestamps restart from 0.
